// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared types, defaults and counter-width helper for the sum block accumulator
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;

  // Beat counter must represent 0..block_len inclusive.
  function automatic int cnt_width(input int block_len);
    return $clog2(block_len + 1);
  endfunction

endpackage

// File: rtl/sum_acc_add.sv
// rtl/sum_acc_add.sv - accumulator adder with carry detect; SUM_ACC_SATURATE_EN selects clamping
module sum_acc_add
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] operand,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] wide;

  // Form the sum one bit wider so the top bit is the carry out of ACC_W.
  always_comb begin
    wide  = {1'b0, acc} + {1'b0, operand};
    carry = wide[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    // Once clamped at all-ones, any nonzero operand carries again, so the clamp sticks.
    sum   = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum   = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/sum_block_accumulator.sv
// rtl/sum_block_accumulator.sv - sums BLOCK_LEN adder beats (or fewer on flush); optional SUM_ACC_SATURATE_EN
module sum_block_accumulator
  import sum_acc_pkg::*;
#(
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  ACC_W     = DEF_ACC_W,
  parameter int  BLOCK_LEN = 4,
  localparam int CNT_W     = cnt_width(BLOCK_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  input  logic              io_flush,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ACC_W-1:0]  io_out_bits,
  output logic [CNT_W-1:0]  io_out_count,
  output logic              io_out_ovf
);

  state_t            state;
  state_t            state_next;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [CNT_W-1:0]  count_inc;
  logic [ACC_W-1:0]  sum;
  logic              carry;
  logic              accept;
  logic              clear;

  assign count_inc = count + CNT_W'(1);

  sum_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc     (acc),
    .operand (ACC_W'(io_in_bits)),
    .sum     (sum),
    .carry   (carry)
  );

  // State register; reset discards any partial block.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; handshake outputs depend only on state.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    clear        = 1'b0;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    case (state)
      ACCUM: begin
        io_in_ready = 1'b1;
        accept      = io_in_valid;
        // A lone flush on an empty block is dropped so no empty block is emitted.
        if ((accept && (count_inc == CNT_W'(BLOCK_LEN))) ||
            (io_flush && (accept || (count != '0)))) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          clear      = 1'b1;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Running total, beat count and sticky overflow; frozen while holding a result.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= sum;
      count <= count_inc;
      ovf   <= ovf | carry;
    end
  end

  assign io_out_bits  = acc;
  assign io_out_count = count;
  assign io_out_ovf   = ovf;

endmodule
